// File: rtl/float_pkg.sv
// Shared definitions for the iterative single-precision-style multiplier:
// FSM state codes, flag bit positions, operand classes and small helpers.
package float_pkg;

    // FSM state codes
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_UNPACK    = 3'd1;
    localparam logic [2:0] ST_MULTIPLY  = 3'd2;
    localparam logic [2:0] ST_NORMALIZE = 3'd3;
    localparam logic [2:0] ST_ROUND     = 3'd4;
    localparam logic [2:0] ST_PACK      = 3'd5;

    // Bit positions inside the 4-bit flags vector
    localparam int FLG_INVALID   = 3;
    localparam int FLG_OVERFLOW  = 2;
    localparam int FLG_UNDERFLOW = 1;
    localparam int FLG_INEXACT   = 0;

    // Operand classes (subnormals are folded into CLS_ZERO)
    localparam logic [1:0] CLS_ZERO   = 2'd0;
    localparam logic [1:0] CLS_NORMAL = 2'd1;
    localparam logic [1:0] CLS_INF    = 2'd2;
    localparam logic [1:0] CLS_NAN    = 2'd3;

    // Exponent bias for a given exponent width
    function automatic int bias_of(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Canonical quiet NaN: sign 0, exponent all ones, only mantissa MSB set.
    // Returned wide; callers truncate to their own format width.
    function automatic logic [63:0] qnan_of(input int exp_w, input int man_w);
        logic [63:0] r;
        r = ((64'd1 << exp_w) - 64'd1) << man_w;
        r = r | (64'd1 << (man_w - 1));
        return r;
    endfunction

    // Classify an operand from its exponent/mantissa summary bits
    function automatic logic [1:0] classify(input logic exp_zero,
                                            input logic exp_ones,
                                            input logic man_nz);
        logic [1:0] c;
        if (exp_zero)      c = CLS_ZERO;
        else if (exp_ones) c = man_nz ? CLS_NAN : CLS_INF;
        else               c = CLS_NORMAL;
        return c;
    endfunction

endpackage

// File: rtl/float_mul_rne_mul.sv
// Iterative shift-add mantissa multiplier. Retires BPC multiplier bits per
// cycle; the first group is retired on the very edge that samples start, so
// done pulses on the N-th step edge (counting the start edge as the first).
module mant_mul_iter #(
    parameter int W   = 24,
    parameter int BPC = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] product,
    output logic           done
);
    localparam int N  = (W + BPC - 1) / BPC;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(N - 1);

    logic [2*W-1:0] mcand_q, acc_q;
    logic [W-1:0]   mplier_q;
    logic [CW-1:0]  cnt_q;
    logic           done_q;

    logic [2*W-1:0] mcand_c, acc_c, partial_c;
    logic [W-1:0]   mplier_c;
    logic           step_c;

    assign step_c = start || (cnt_q != '0);

    // Select fresh operands on start, then form the partial product of the
    // low BPC multiplier bits as a sum of shifted multiplicands.
    always_comb begin
        mcand_c   = start ? {{W{1'b0}}, a} : mcand_q;
        mplier_c  = start ? b : mplier_q;
        acc_c     = start ? '0 : acc_q;
        partial_c = '0;
        for (int j = 0; j < BPC; j++) begin
            if (mplier_c[j]) partial_c = partial_c + (mcand_c << j);
        end
    end

    // Step counter and done pulse; cleared by reset so no stale done survives
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else if (start) begin
            cnt_q  <= CNT_LOAD;
            done_q <= (N == 1);
        end else if (cnt_q != '0) begin
            cnt_q  <= cnt_q - CNT_ONE;
            done_q <= (cnt_q == CNT_ONE);
        end else begin
            done_q <= 1'b0;
        end
    end

    // Accumulate and shift; datapath needs no reset value
    always_ff @(posedge clk) begin
        if (step_c) begin
            acc_q    <= acc_c + partial_c;
            mcand_q  <= mcand_c << BPC;
            mplier_q <= mplier_c >> BPC;
        end
    end

    assign product = acc_q;
    assign done    = done_q;

endmodule

// File: rtl/float_mul_rne.sv
// Multi-cycle floating-point multiplier, round-to-nearest-even, DAZ/FTZ.
// Sequence: IDLE -> UNPACK -> (MULTIPLY -> NORMALIZE -> ROUND ->) PACK.
// Handshake: req is only looked at in IDLE; ack is a one-cycle pulse that
// comes with out/flags, and out/flags hold until the next ack.
module float_mul_rne
    import float_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int BPC   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 ack,
    output logic [EXP_W+MAN_W:0] out,
    output logic [3:0]           flags,
    output logic                 busy,
    output logic [2:0]           dbg_state_o
);
    localparam int FW = 1 + EXP_W + MAN_W;
    localparam int W  = MAN_W + 1;
    localparam int PW = 2 * W;
    localparam logic [FW-1:0] QNAN = FW'(qnan_of(EXP_W, MAN_W));
    localparam logic signed [EXP_W+1:0] BIAS_E = (EXP_W+2)'(bias_of(EXP_W));
    localparam logic signed [EXP_W+1:0] E_MAX  = (EXP_W+2)'((1 << EXP_W) - 1);
    localparam logic signed [EXP_W+1:0] E_ONE  = (EXP_W+2)'(1);
    localparam logic signed [EXP_W+1:0] E_ZERO = '0;

    // Control / output registers
    logic [2:0]    state_q;
    logic          ack_q;
    logic [FW-1:0] out_q;
    logic [3:0]    flags_q;

    // Datapath registers
    logic [FW-1:0]             a_q, b_q;
    logic                      sign_q, special_q, spec_inv_q;
    logic [FW-1:0]             spec_out_q;
    logic [PW-1:0]             prod_q;
    logic signed [EXP_W+1:0]   e_q;
    logic [MAN_W-1:0]          mant_q;
    logic                      g_q, r_q, s_q, inexact_q;

    // Unpack view of the latched operands
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_man, b_man;
    logic [1:0]       a_cls, b_cls;
    logic             sign_c, special_c, spec_inv_c;
    logic [FW-1:0]    spec_out_c;

    assign a_exp  = a_q[FW-2:MAN_W];
    assign b_exp  = b_q[FW-2:MAN_W];
    assign a_man  = a_q[MAN_W-1:0];
    assign b_man  = b_q[MAN_W-1:0];
    assign a_cls  = classify(a_exp == '0, &a_exp, |a_man);
    assign b_cls  = classify(b_exp == '0, &b_exp, |b_man);
    assign sign_c = a_q[FW-1] ^ b_q[FW-1];
    assign special_c = (a_cls != CLS_NORMAL) || (b_cls != CLS_NORMAL);

    // Result for the special path (NaN, inf, zero operands)
    always_comb begin
        spec_out_c = '0;
        spec_inv_c = 1'b0;
        if ((a_cls == CLS_NAN) || (b_cls == CLS_NAN) ||
            ((a_cls == CLS_INF) && (b_cls == CLS_ZERO)) ||
            ((a_cls == CLS_ZERO) && (b_cls == CLS_INF))) begin
            spec_out_c = QNAN;
            spec_inv_c = 1'b1;
        end else if ((a_cls == CLS_INF) || (b_cls == CLS_INF)) begin
            spec_out_c = {sign_c, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else begin
            spec_out_c = {sign_c, {(FW-1){1'b0}}};
        end
    end

    // Mantissa multiplier, launched straight out of UNPACK
    logic          start_c, mul_done;
    logic [PW-1:0] mul_prod;

    assign start_c = (state_q == ST_UNPACK) && !special_c;

    mant_mul_iter #(.W(W), .BPC(BPC)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (start_c),
        .a       ({1'b1, a_man}),
        .b       ({1'b1, b_man}),
        .product (mul_prod),
        .done    (mul_done)
    );

    // Normalize: product is in [1,4); drop the leading one and keep G/R/S
    logic [PW-2:0]    norm_c;
    logic [MAN_W-1:0] nmant_c;
    logic             guard_c, round_c, sticky_c;

    assign norm_c   = prod_q[PW-1] ? prod_q[PW-2:0] : {prod_q[PW-3:0], 1'b0};
    assign nmant_c  = norm_c[PW-2 -: MAN_W];
    assign guard_c  = norm_c[MAN_W];
    assign round_c  = norm_c[MAN_W-1];
    assign sticky_c = |norm_c[MAN_W-2:0];

    // Round to nearest even; a carry-out leaves the mantissa at zero
    logic           round_up_c;
    logic [MAN_W:0] mant_inc_c;

    assign round_up_c = g_q & (r_q | s_q | mant_q[0]);
    assign mant_inc_c = {1'b0, mant_q} + {{MAN_W{1'b0}}, round_up_c};

    // Final result selection with overflow to inf and flush-to-zero
    logic [FW-1:0] pack_out_c;
    logic [3:0]    pack_flags_c;

    always_comb begin
        pack_out_c   = '0;
        pack_flags_c = '0;
        if (special_q) begin
            pack_out_c                = spec_out_q;
            pack_flags_c[FLG_INVALID] = spec_inv_q;
        end else if (e_q >= E_MAX) begin
            pack_out_c                 = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            pack_flags_c[FLG_OVERFLOW] = 1'b1;
            pack_flags_c[FLG_INEXACT]  = 1'b1;
        end else if (e_q <= E_ZERO) begin
            pack_out_c                  = {sign_q, {(FW-1){1'b0}}};
            pack_flags_c[FLG_UNDERFLOW] = 1'b1;
            pack_flags_c[FLG_INEXACT]   = 1'b1;
        end else begin
            pack_out_c                = {sign_q, e_q[EXP_W-1:0], mant_q};
            pack_flags_c[FLG_INEXACT] = inexact_q;
        end
    end

    // FSM and output registers; reset aborts any operation immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            out_q   <= '0;
            flags_q <= '0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                ST_IDLE:      if (req) state_q <= ST_UNPACK;
                ST_UNPACK:    state_q <= special_c ? ST_PACK : ST_MULTIPLY;
                ST_MULTIPLY:  if (mul_done) state_q <= ST_NORMALIZE;
                ST_NORMALIZE: state_q <= ST_ROUND;
                ST_ROUND:     state_q <= ST_PACK;
                ST_PACK: begin
                    out_q   <= pack_out_c;
                    flags_q <= pack_flags_c;
                    ack_q   <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default:      state_q <= ST_IDLE;
            endcase
        end
    end

    // Datapath stepping, one stage per FSM state
    always_ff @(posedge clk) begin
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    a_q <= a;
                    b_q <= b;
                end
            end
            ST_UNPACK: begin
                sign_q     <= sign_c;
                special_q  <= special_c;
                spec_out_q <= spec_out_c;
                spec_inv_q <= spec_inv_c;
            end
            ST_MULTIPLY: begin
                if (mul_done) begin
                    prod_q <= mul_prod;
                    e_q    <= $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - BIAS_E;
                end
            end
            ST_NORMALIZE: begin
                mant_q <= nmant_c;
                g_q    <= guard_c;
                r_q    <= round_c;
                s_q    <= sticky_c;
                if (prod_q[PW-1]) e_q <= e_q + E_ONE;
            end
            ST_ROUND: begin
                mant_q    <= mant_inc_c[MAN_W-1:0];
                inexact_q <= g_q | r_q | s_q;
                if (mant_inc_c[MAN_W]) e_q <= e_q + E_ONE;
            end
            default: ;
        endcase
    end

    assign ack         = ack_q;
    assign out         = out_q;
    assign flags       = flags_q;
    assign busy        = (state_q != ST_IDLE);
    assign dbg_state_o = state_q;

endmodule
